uart_parity_engine: RTL and testbench
=====================================

# uart_parity_engine

Serial, frame-aware parity engine for the UART receive path: accumulates parity on data bits as the bit sampler delivers them, then checks the received parity bit against even, odd, mark or space parity. Data width is parametrised. The block keeps per-frame result, sticky-error and saturating error-count status for the RX controller and the register file. It sits between the data sampler/edge counter and the RX FSM, replacing the whole-byte parallel check.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9
- CNT_WIDTH, 8, width of the saturating error counter
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse; start bit detected; starts a new frame in any state
- bit_valid  in  1  pulse; sampled_bit is valid this cycle
- sampled_bit  in  1  majority-voted bit from the sampler
- parity_en  in  1  frame includes a parity bit; latched at frame_start
- parity_mode  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0); latched at frame_start
- err_clr  in  1  pulse; clears err_sticky and err_count
- busy  out  1  frame in progress (state DATA or PARITY)
- result_valid  out  1  one-cycle pulse; parity_err is updated
- parity_err  out  1  result for the last completed frame; held until the next result_valid
- err_sticky  out  1  set by any parity error; cleared only by err_clr or RST
- err_count  out  CNT_WIDTH  count of parity errors; saturates at all-ones

## Operation
- States: IDLE, DATA, PARITY, DONE. Reset state is IDLE.
- Reset values: all outputs 0. Internal accumulator, bit counter and latched mode are also 0.
- Any state, frame_start=1: go to DATA. Clear the accumulator and bit counter. Latch parity_en and parity_mode. An unfinished frame is abandoned with no result_valid. frame_start has priority over bit_valid in the same cycle, and that bit is ignored.
- IDLE: bit_valid is ignored.
- DATA: on each bit_valid, acc <= acc ^ sampled_bit and the counter increments. On the DATA_WIDTH-th bit:
  - go to PARITY if latched parity_en=1;
  - otherwise go to DONE.
- PARITY: on bit_valid, compute err = (sampled_bit != expected), then go to DONE. Expected parity by latched mode:
  - even: expected = acc
  - odd: expected = ~acc
  - mark: expected = 1
  - space: expected = 0
- DONE (one cycle):
  - result_valid=1 and parity_err is loaded; parity_err=0 when parity is disabled;
  - on error: err_sticky<=1 and err_count increments unless it is all-ones;
  - next state is IDLE, or DATA if frame_start is asserted.
- err_clr:
  - clears err_sticky and err_count in any state;
  - if it coincides with an error in DONE, the error wins over the clear: sticky=1, count=1.
- parity_en or parity_mode changing mid-frame has no effect on the current frame.
- Bit counter width is $clog2(DATA_WIDTH+1). The counter is compared against DATA_WIDTH, not wrapped.

## Timing
- All outputs are registered.
- busy rises the cycle after frame_start.
- result_valid is asserted the cycle after the parity bit's bit_valid, or after the last data bit's bit_valid when parity is disabled.
- parity_err, err_sticky and err_count update on the same edge that asserts result_valid.
- busy falls on the same edge that asserts result_valid.
- Back-to-back frames: frame_start may arrive in the DONE cycle. No cycle is lost and result_valid still pulses.
- bit_valid pulses may be any distance apart, including consecutive cycles.
- RST asserted mid-frame: immediate return to IDLE with all outputs 0. No result_valid is produced for the aborted frame.

## Test plan
- Even parity, DATA_WIDTH=8, data 0xA5 sent LSB first, parity bit 0 -> one result_valid pulse, parity_err=0, err_count=0.
- Odd parity, data 0xA5, parity bit 0 -> parity_err=1, err_sticky=1, err_count=1; a following odd frame 0x01 with parity bit 0 -> parity_err=0, count stays 1.
- Mark, then space, data 0x00:
  - mark with parity bit 1 -> err=0;
  - space with parity bit 1 -> err=1;
  - parity_en=0 frame -> result_valid after the 8th bit, no parity bit consumed, err=0.
- frame_start after 4 data bits -> no result_valid, accumulator restarts; the new frame 0xFF with even parity bit 0 -> err=0. RST mid-frame -> busy=0 and all outputs 0 immediately.
- CNT_WIDTH=2 with 5 consecutive error frames -> err_count saturates at 3.
- err_clr in the same cycle as an error result -> err_count=1, err_sticky=1.

Source files
------------

// File: rtl/uart_parity_engine.sv
// Bit-serial UART receive parity engine: accumulates data-bit parity as the sampler
// delivers bits, checks the parity bit, and keeps per-frame, sticky and counted error status.
module uart_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 frame_start,
    input  logic                 bit_valid,
    input  logic                 sampled_bit,
    input  logic                 parity_en,
    input  logic [1:0]           parity_mode,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 parity_err,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 en_q, en_d;
    logic [1:0]           mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 result_q, result_d;
    logic                 parity_err_q, parity_err_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 expected;
    logic                 err_event;

    always_comb begin
        unique case (mode_q)
            2'b00:   expected = acc_q;
            2'b01:   expected = ~acc_q;
            2'b10:   expected = 1'b1;
            default: expected = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        en_d         = en_q;
        mode_d       = mode_q;
        result_d     = 1'b0;
        parity_err_d = parity_err_q;
        sticky_d     = sticky_q;
        count_d      = count_q;
        err_event    = 1'b0;

        if (err_clr) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end

        if (frame_start) begin
            // A new start bit abandons any frame in flight, including a bit arriving this cycle.
            state_d   = DATA;
            acc_d     = 1'b0;
            bit_cnt_d = '0;
            en_d      = parity_en;
            mode_d    = parity_mode;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                DATA: begin
                    if (bit_valid) begin
                        acc_d     = acc_q ^ sampled_bit;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_d == BW'(DATA_WIDTH)) begin
                            if (en_q) begin
                                state_d = PARITY;
                            end else begin
                                state_d      = DONE;
                                result_d     = 1'b1;
                                parity_err_d = 1'b0;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        state_d      = DONE;
                        result_d     = 1'b1;
                        parity_err_d = (sampled_bit != expected);
                        err_event    = parity_err_d;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Status is loaded on the edge that enters DONE, so an error overrides a same-cycle clear.
        if (err_event) begin
            sticky_d = 1'b1;
            if (count_d != '1) begin
                count_d = count_d + CNT_WIDTH'(1);
            end
        end

        busy_d = (state_d == DATA) || (state_d == PARITY);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            bit_cnt_q    <= '0;
            en_q         <= 1'b0;
            mode_q       <= 2'b00;
            busy_q       <= 1'b0;
            result_q     <= 1'b0;
            parity_err_q <= 1'b0;
            sticky_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            en_q         <= en_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            result_q     <= result_d;
            parity_err_q <= parity_err_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_q;
    assign parity_err   = parity_err_q;
    assign err_sticky   = sticky_q;
    assign err_count    = count_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: two instances (8-bit and 2-bit error counters)
// share stimulus; the driver queues expected results and a monitor checks each result_valid.
module tb_uart_parity_engine;

    logic       CLK;
    logic       RST;
    logic       frame_start;
    logic       bit_valid;
    logic       sampled_bit;
    logic       parity_en;
    logic [1:0] parity_mode;
    logic       err_clr;

    logic       busy_a, rv_a, perr_a, sticky_a;
    logic [7:0] cnt_a;
    logic       busy_b, rv_b, perr_b, sticky_b;
    logic [1:0] cnt_b;

    uart_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .parity_en(parity_en), .parity_mode(parity_mode),
        .err_clr(err_clr), .busy(busy_a), .result_valid(rv_a), .parity_err(perr_a),
        .err_sticky(sticky_a), .err_count(cnt_a)
    );

    uart_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .parity_en(parity_en), .parity_mode(parity_mode),
        .err_clr(err_clr), .busy(busy_b), .result_valid(rv_b), .parity_err(perr_b),
        .err_sticky(sticky_b), .err_count(cnt_b)
    );

    typedef struct packed {
        logic       err;
        logic       sticky;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic       m_sticky = 1'b0;
    logic [7:0] m_cnt8   = 8'd0;
    logic [1:0] m_cnt2   = 2'd0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model of the status registers; the per-frame error is hand-computed in the vectors.
    task automatic push_exp(input logic err, input logic clr);
        exp_t e;
        if (clr) begin
            m_sticky = 1'b0;
            m_cnt8   = 8'd0;
            m_cnt2   = 2'd0;
        end
        if (err) begin
            m_sticky = 1'b1;
            if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
            if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
        end
        e.err = err; e.sticky = m_sticky; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2;
        q.push_back(e);
    endtask

    task automatic start_frame(input logic en, input logic [1:0] mode);
        frame_start = 1'b1;
        parity_en   = en;
        parity_mode = mode;
        tick();
        frame_start = 1'b0;
        // Scramble the config mid-frame; the latched copy must be used.
        parity_en   = ~en;
        parity_mode = ~mode;
        check("busy_after_start", {busy_a, busy_b}, 2'b11);
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_valid   = 1'b1;
        sampled_bit = b;
        tick();
        bit_valid   = 1'b0;
        sampled_bit = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic en, input logic [1:0] mode, input logic [7:0] data,
                              input logic pbit, input int gap, input logic clr, input logic exp_err);
        start_frame(en, mode);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && !en) push_exp(1'b0, 1'b0);
            send_bit(data[i], (i == 7 && !en) ? 0 : gap);
        end
        if (en) begin
            push_exp(exp_err, clr);
            err_clr = clr;
            bit_valid   = 1'b1;
            sampled_bit = pbit;
            tick();
            bit_valid   = 1'b0;
            sampled_bit = 1'b0;
            err_clr     = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   {busy_a, busy_b}, 2'b00);
        check({tag, "_rv"},     {rv_a, rv_b}, 2'b00);
        check({tag, "_perr"},   {perr_a, perr_b}, 2'b00);
        check({tag, "_sticky"}, {sticky_a, sticky_b}, 2'b00);
        check({tag, "_count"},  {22'd0, cnt_a, cnt_b}, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            check("rv_agree", rv_a, rv_b);
            if (rv_a) begin
                check("result_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("parity_err",      perr_a,   e.err);
                    check("parity_err_sat",  perr_b,   e.err);
                    check("err_sticky",      sticky_a, e.sticky);
                    check("err_count",       cnt_a,    e.cnt8);
                    check("err_count_sat",   cnt_b,    e.cnt2);
                    check("busy_at_result",  busy_a,   1'b0);
                end
            end
        end
    end

    initial begin
        frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        parity_en = 1'b0; parity_mode = 2'b00; err_clr = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST = 1'b0;
        tick();

        // en, mode, data, parity bit, gap, clear-with-parity, expected error
        send_frame(1'b1, 2'b00, 8'hA5, 1'b0, 0, 1'b0, 1'b0); // even ok
        send_frame(1'b1, 2'b01, 8'hA5, 1'b0, 2, 1'b0, 1'b1); // odd error
        send_frame(1'b1, 2'b01, 8'h01, 1'b0, 1, 1'b0, 1'b0); // odd ok
        send_frame(1'b1, 2'b10, 8'h00, 1'b1, 0, 1'b0, 1'b0); // mark ok
        send_frame(1'b1, 2'b11, 8'h00, 1'b1, 3, 1'b0, 1'b1); // space error
        send_frame(1'b0, 2'b00, 8'h00, 1'b0, 0, 1'b0, 1'b0); // parity disabled
        tick();
        check("idle_after_noparity", busy_a, 1'b0);
        send_bit(1'b1, 2);                                  // stray bit in IDLE

        // Abandon a frame after 4 bits, then a fresh 0xFF even frame.
        start_frame(1'b1, 2'b00);
        for (int i = 0; i < 4; i++) send_bit(1'b1, (i == 1) ? 1 : 0);
        send_frame(1'b1, 2'b00, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset mid-frame.
        start_frame(1'b1, 2'b01);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
        RST = 1'b1;
        #1;
        check_all_zero("mid_reset");
        m_sticky = 1'b0; m_cnt8 = 8'd0; m_cnt2 = 2'd0;
        tick();
        RST = 1'b0;
        tick();

        // Five back-to-back odd errors: 2-bit counter saturates at 3.
        for (int f = 0; f < 5; f++) send_frame(1'b1, 2'b01, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        // Clear coinciding with an error result: error wins, count restarts at 1.
        send_frame(1'b1, 2'b01, 8'h00, 1'b0, 0, 1'b1, 1'b1);
        repeat (2) tick();

        // Standalone clear, then a clean frame.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_sticky = 1'b0; m_cnt8 = 8'd0; m_cnt2 = 2'd0;
        check("clr_count", {22'd0, cnt_a, cnt_b}, 32'd0);
        check("clr_sticky", {sticky_a, sticky_b}, 2'b00);
        send_frame(1'b1, 2'b00, 8'h00, 1'b0, 1, 1'b0, 1'b0);

        for (int n = 0; n < 50 && q.size() != 0; n++) tick();
        repeat (3) tick();
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
